// File: rtl/frame_snapshot_ctrl_pkg.sv
// frame_snapshot_ctrl_pkg: state encodings and buffer sizing shared by the snapshot controller.
package frame_snapshot_ctrl_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ARM = 2'd1, ST_COPY = 2'd2, ST_GAP = 2'd3} state_t;
  localparam int BUF_DEPTH = 65536;
  localparam int COPY_TO_DEF = BUF_DEPTH + 4464;
  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [1:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {7'b0, b};
    return s[8] ? 8'hff : s[7:0];
  endfunction
endpackage

// File: rtl/frame_snapshot_ctrl_if.sv
// frame_snapshot_ctrl_if: request, buffer handshake and status signals of the snapshot controller.
interface frame_snapshot_ctrl_if;
  import frame_snapshot_ctrl_pkg::*;
  logic       frame_end, auto_en, capture_req, err_clr, buf_done;
  logic       buf_rd, busy, snap_done, snap_src, err_timeout;
  logic [7:0] drop_cnt;
  state_t     state_o;
  modport master(output frame_end, auto_en, capture_req, err_clr, buf_done,
                 input buf_rd, busy, snap_done, snap_src, err_timeout, drop_cnt, state_o);
  modport slave(input frame_end, auto_en, capture_req, err_clr, buf_done,
                output buf_rd, busy, snap_done, snap_src, err_timeout, drop_cnt, state_o);
endinterface

// File: rtl/frame_snapshot_ctrl_decim.sv
// frame_snapshot_ctrl_decim: frame_end decimator raising the pending auto-snapshot flag.
module frame_snapshot_ctrl_decim #(
  parameter int DECIM = 1
) (
  input  logic r_clk,
  input  logic rst_n,
  input  logic i_frame_end,
  input  logic i_auto_en,
  input  logic i_clr,
  output logic o_pend,
  output logic o_drop
);
  logic [7:0] r_cnt;
  logic       r_pend;
  logic       w_hit;
  assign w_hit  = i_frame_end && i_auto_en && r_cnt == 8'(DECIM - 1);
  assign o_drop = w_hit && r_pend && !i_clr;
  assign o_pend = r_pend;
  always_ff @(posedge r_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_pend <= 1'b0;
    end else begin
      if (i_frame_end && i_auto_en) r_cnt <= w_hit ? 8'd0 : r_cnt + 8'd1;
      r_pend <= w_hit || (r_pend && !i_clr);
    end
  end
endmodule

// File: rtl/frame_snapshot_ctrl.sv
// frame_snapshot_ctrl: arbitrates auto/manual snapshot requests and sequences the buffer copy with timeouts.
module frame_snapshot_ctrl
  import frame_snapshot_ctrl_pkg::*;
#(
  parameter int DECIM   = 1,
  parameter int BUSY_TO = 16,
  parameter int COPY_TO = COPY_TO_DEF,
  parameter int GAP     = 4
) (
  input logic               r_clk,
  input logic               rst_n,
  frame_snapshot_ctrl_if.slave bus
);
  localparam int TW = $clog2(COPY_TO + 1);
  state_t        r_state;
  logic [TW-1:0] r_timer;
  logic          r_pend_man, r_buf_rd, r_busy, r_snap_done, r_snap_src, r_err;
  logic [7:0]    r_drop;
  logic          w_pend_auto, w_drop_auto, w_drop_man, w_take_man, w_take_auto;
  assign w_take_man  = r_state == ST_IDLE && r_pend_man;
  assign w_take_auto = r_state == ST_IDLE && !r_pend_man && w_pend_auto && bus.buf_done;
  assign w_drop_man  = bus.capture_req && r_pend_man && !w_take_man;
  assign bus.buf_rd      = r_buf_rd;
  assign bus.busy        = r_busy;
  assign bus.snap_done   = r_snap_done;
  assign bus.snap_src    = r_snap_src;
  assign bus.err_timeout = r_err;
  assign bus.drop_cnt    = r_drop;
  assign bus.state_o     = r_state;
  frame_snapshot_ctrl_decim #(.DECIM(DECIM)) u_decim (
    .r_clk      (r_clk),
    .rst_n      (rst_n),
    .i_frame_end(bus.frame_end),
    .i_auto_en  (bus.auto_en),
    .i_clr      (w_take_auto),
    .o_pend     (w_pend_auto),
    .o_drop     (w_drop_auto)
  );
  // a request landing on the cycle its flag is consumed re-arms the flag instead of dropping
  always_ff @(posedge r_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_man <= 1'b0;
      r_drop     <= '0;
    end else begin
      r_pend_man <= bus.capture_req || (r_pend_man && !w_take_man);
      r_drop     <= bus.err_clr ? 8'd0 : sat_add(r_drop, 2'(w_drop_man) + 2'(w_drop_auto));
    end
  end
  always_ff @(posedge r_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_timer     <= '0;
      r_buf_rd    <= 1'b0;
      r_busy      <= 1'b0;
      r_snap_done <= 1'b0;
      r_snap_src  <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_snap_done <= 1'b0;
      if (bus.err_clr) r_err <= 1'b0;
      case (r_state)
        ST_IDLE: if (w_take_man || w_take_auto) begin
          r_state    <= ST_ARM;
          r_timer    <= '0;
          r_buf_rd   <= 1'b1;
          r_busy     <= 1'b1;
          r_snap_src <= w_take_man;
        end
        ST_ARM: if (!bus.buf_done) begin
          r_state <= ST_COPY;
          r_timer <= '0;
        end else if (r_timer == TW'(BUSY_TO - 1)) begin
          r_state  <= ST_GAP;
          r_timer  <= '0;
          r_buf_rd <= 1'b0;
          r_err    <= 1'b1;
        end else r_timer <= r_timer + 1'b1;
        ST_COPY: if (bus.buf_done || r_timer == TW'(COPY_TO - 1)) begin
          r_state     <= ST_GAP;
          r_timer     <= '0;
          r_buf_rd    <= 1'b0;
          r_snap_done <= bus.buf_done;
          if (!bus.buf_done) r_err <= 1'b1;
        end else r_timer <= r_timer + 1'b1;
        default: if (r_timer == TW'(GAP - 1)) begin
          r_state <= ST_IDLE;
          r_timer <= '0;
          r_busy  <= 1'b0;
        end else r_timer <= r_timer + 1'b1;
      endcase
    end
  end
endmodule

// File: tb/tb_frame_snapshot_ctrl.sv
// tb_frame_snapshot_ctrl: directed stimulus against a cycle model of the snapshot rules plus literal expectations.
module tb_frame_snapshot_ctrl;
  localparam int DECIM = 3, BUSY_TO = 16, COPY_TO = 40, GAP = 4, CLEN = 20;
  logic clk = 1'b0, rst_n = 1'b0;
  int vectors = 0, errors = 0;
  int buf_mode = 0, k = 0, tot_snap = 0;
  int n_hi, n_gap, n_arm, n_copy, first_hi, s0;
  frame_snapshot_ctrl_if bus();
  frame_snapshot_ctrl #(.DECIM(DECIM), .BUSY_TO(BUSY_TO), .COPY_TO(COPY_TO), .GAP(GAP)) dut (
    .r_clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  // buffer: r_done drops 3 samples after r_rd rises, stays low CLEN samples; mode 1 never drops, mode 2 never recovers
  always @(negedge clk) begin
    k = bus.buf_rd ? k + 1 : 0;
    bus.buf_done = buf_mode == 1 ? 1'b1 : buf_mode == 2 ? !(k >= 3) : !(k >= 3 && k < 3 + CLEN);
  end

  int m_st = 0, m_left = 0, fcnt = 0, m_drop = 0;
  bit pm = 0, pa = 0, m_snap = 0, m_src = 0, m_err = 0;
  always @(posedge clk or negedge rst_n) begin
    bit tm, ta, hit;
    int nd;
    if (!rst_n) begin
      m_st = 0; m_left = 0; fcnt = 0; m_drop = 0;
      pm = 0; pa = 0; m_snap = 0; m_src = 0; m_err = 0;
    end else begin
      tm = m_st == 0 && pm;
      ta = m_st == 0 && !pm && pa && bus.buf_done;
      hit = 0;
      if (bus.frame_end && bus.auto_en) begin
        fcnt = fcnt + 1;
        if (fcnt == DECIM) begin fcnt = 0; hit = 1; end
      end
      nd = m_drop + int'(bus.capture_req && pm && !tm) + int'(hit && pa && !ta);
      m_drop = bus.err_clr ? 0 : (nd > 255 ? 255 : nd);
      if (bus.err_clr) m_err = 0;
      m_snap = 0;
      case (m_st)
        0: if (tm || ta) begin m_st = 1; m_left = BUSY_TO; m_src = tm; end
        1: if (!bus.buf_done) begin m_st = 2; m_left = COPY_TO; end
           else begin m_left = m_left - 1; if (m_left == 0) begin m_err = 1; m_st = 3; m_left = GAP; end end
        2: if (bus.buf_done) begin m_snap = 1; m_st = 3; m_left = GAP; end
           else begin m_left = m_left - 1; if (m_left == 0) begin m_err = 1; m_st = 3; m_left = GAP; end end
        default: begin m_left = m_left - 1; if (m_left == 0) m_st = 0; end
      endcase
      pm = bus.capture_req || (pm && !tm);
      pa = hit || (pa && !ta);
    end
  end

  always @(negedge clk) if (rst_n) begin
    logic [14:0] exp_v, act_v;
    exp_v = {m_st == 1 || m_st == 2, m_st != 0, m_snap, m_src, m_err, 8'(m_drop), 2'(m_st)};
    act_v = {bus.buf_rd, bus.busy, bus.snap_done, bus.snap_src, bus.err_timeout, bus.drop_cnt, bus.state_o};
    vectors++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL cycle_model t=%0t: got %b, want %b (rd,busy,done,src,err,drop,st)", $time, act_v, exp_v);
    end
    if (bus.snap_done) tot_snap++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp_v);
    end
  endtask

  task automatic pulse(input logic f, input logic c, input logic e);
    @(negedge clk);
    bus.frame_end = f; bus.capture_req = c; bus.err_clr = e;
    @(negedge clk);
    bus.frame_end = 0; bus.capture_req = 0; bus.err_clr = 0;
  endtask

  task automatic settle(input string name);
    int run = 0;
    n_hi = 0; n_gap = 0; n_arm = 0; n_copy = 0; first_hi = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.buf_rd) begin n_hi++; if (first_hi < 0) first_hi = i; end
      if (bus.state_o == 1) n_arm++;
      if (bus.state_o == 2) n_copy++;
      if (bus.state_o == 3) n_gap++;
      run = bus.busy ? 0 : run + 1;
      if (run >= 3) return;
    end
    check({name, "_settle_timeout"}, 1, 0);
  endtask

  initial begin
    bus.frame_end = 0; bus.auto_en = 0; bus.capture_req = 0; bus.err_clr = 0; bus.buf_done = 1;
    repeat (3) @(negedge clk);
    check("reset_outputs", {bus.buf_rd, bus.busy, bus.snap_done, bus.snap_src, bus.err_timeout, bus.drop_cnt, bus.state_o}, 0);
    #2 rst_n = 1;
    // manual capture
    s0 = tot_snap;
    pulse(0, 1, 0);
    check("man_rd_t1", bus.buf_rd, 0);
    settle("man");
    check("man_rd_t2", first_hi, 0);
    check("man_rd_len", n_hi, 23);
    check("man_gap", n_gap, 4);
    check("man_snaps", tot_snap - s0, 1);
    check("man_src", bus.snap_src, 1);
    // decimated auto snapshots
    bus.auto_en = 1;
    s0 = tot_snap;
    for (int i = 0; i < 7; i++) begin pulse(1, 0, 0); settle("auto"); end
    check("auto_snaps", tot_snap - s0, 2);
    check("auto_src", bus.snap_src, 0);
    check("auto_drop", bus.drop_cnt, 0);
    // coincident auto and manual request
    pulse(1, 0, 0);
    settle("pre_both");
    s0 = tot_snap;
    pulse(1, 1, 0);
    settle("both");
    check("both_snaps", tot_snap - s0, 2);
    check("both_src_last", bus.snap_src, 0);
    check("both_drop", bus.drop_cnt, 0);
    // auto disabled: frame_end ignored
    bus.auto_en = 0;
    s0 = tot_snap;
    for (int i = 0; i < 3; i++) pulse(1, 0, 0);
    settle("noauto");
    check("noauto_snaps", tot_snap - s0, 0);
    // extra requests during a copy
    s0 = tot_snap;
    pulse(0, 1, 0);
    repeat (6) @(negedge clk);
    pulse(0, 1, 0);
    repeat (2) @(negedge clk);
    pulse(0, 1, 0);
    settle("busy_req");
    check("busy_snaps", tot_snap - s0, 2);
    check("busy_drop", bus.drop_cnt, 1);
    pulse(0, 0, 1);
    check("drop_clr", bus.drop_cnt, 0);
    // r_done never falls
    buf_mode = 1;
    s0 = tot_snap;
    pulse(0, 1, 0);
    settle("arm_to");
    check("arm_to_len", n_arm, 16);
    check("arm_to_err", bus.err_timeout, 1);
    check("arm_to_snaps", tot_snap - s0, 0);
    check("arm_to_state", bus.state_o, 0);
    pulse(0, 0, 1);
    check("err_clr", bus.err_timeout, 0);
    // r_done stuck low
    buf_mode = 2;
    s0 = tot_snap;
    pulse(0, 1, 0);
    settle("copy_to");
    check("copy_to_len", n_copy, COPY_TO);
    check("copy_to_err", bus.err_timeout, 1);
    check("copy_to_snaps", tot_snap - s0, 0);
    pulse(0, 0, 1);
    // async reset mid-copy
    buf_mode = 0;
    pulse(0, 1, 0);
    for (int i = 0; i < 20 && bus.state_o != 2; i++) @(negedge clk);
    check("pre_rst_copy", bus.state_o, 2);
    @(posedge clk);
    #3 rst_n = 0;
    #1 check("async_rst", {bus.buf_rd, bus.busy, bus.state_o}, 0);
    @(negedge clk);
    #2 rst_n = 1;
    s0 = tot_snap;
    pulse(0, 1, 0);
    settle("post_rst");
    check("post_rst_snaps", tot_snap - s0, 1);
    check("post_rst_err", bus.err_timeout, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/frame_snapshot_ctrl.md
Name: frame_snapshot_ctrl

Overview:
Sequencer for the dual-port frame buffer's snapshot copy, which moves the port-A write image into the port-B display image. It runs in the read-clock domain, decides when a copy runs, and drives the buffer's read-request level (r_rd) for the whole copy. It watches the buffer's r_done flag and recovers from stalls with timeouts. It also shares the single copy engine between two requesters: a periodic camera end-of-frame trigger and a manual capture request.

Parameters:
DECIM, 1, automatic snapshot on every DECIMth frame_end pulse (1..255)
BUSY_TO, 16, max cycles from r_rd rise to r_done falling
COPY_TO, 70000, max cycles r_done may stay low (must exceed 65538)
GAP, 4, min cycles r_rd held low between copies (>=2 for the buffer's edge detector)

Ports:
r_clk  in  1  read clock (50 MHz); sole clock
rst_n  in  1  asynchronous active-low reset
frame_end  in  1  one-cycle pulse, camera frame complete, already synchronised to r_clk
auto_en  in  1  enables frame_end-driven snapshots
capture_req  in  1  one-cycle manual snapshot request
err_clr  in  1  one-cycle pulse, clears err_timeout and drop_cnt
buf_done  in  1  buffer r_done (1 = idle/copy complete)
buf_rd  out  1  to buffer r_rd; held high for the whole copy
busy  out  1  high from ARM through GAP
snap_done  out  1  one-cycle pulse, copy completed normally
snap_src  out  1  source of current/last copy: 0 = auto, 1 = manual
err_timeout  out  1  sticky, a timeout occurred
drop_cnt  out  8  saturating count of discarded requests
state_o  out  2  current state, for the LED debug pins

Behaviour:
- Reset (async, rst_n=0): state IDLE, all outputs 0, frame decimator 0, pending flags 0, timer 0. Reset mid-copy drops buf_rd at once; the buffer then stalls its copy (it advances only while r_rd=1), which is acceptable.
- Decimator: 8-bit counter, incremented on frame_end when auto_en=1. On reaching DECIM-1 it wraps to 0 and sets pend_auto. With auto_en=0 the decimator holds and pend_auto is not set.
- Pending flags:
  - capture_req sets pend_man.
  - A request arriving while its flag is already set increments drop_cnt (saturates at 255).
  - Simultaneous auto and manual requests set both flags; no drop.
- States (encoding 0..3):
  - IDLE: buf_rd=0. If pend_man, or pend_auto with buf_done=1: go to ARM. Manual has priority. The selected flag is cleared and snap_src is latched.
  - ARM: buf_rd=1, timer counts. buf_done=0 -> COPY, timer cleared. Timer reaches BUSY_TO -> err_timeout=1, go to GAP.
  - COPY: buf_rd=1. buf_done=1 -> snap_done pulse for 1 cycle, go to GAP. Timer reaches COPY_TO -> err_timeout=1, go to GAP, no snap_done.
  - GAP: buf_rd=0, count GAP cycles, then go to IDLE.
- Latency: request pulse at cycle t gives buf_rd=1 at t+2 (flag registered at t+1, ARM entered at t+2). All outputs are registered.
- busy=1 in ARM, COPY and GAP. Requests arriving while busy only set pending flags; they never abort a copy.
- err_clr coinciding with a new drop: the clear wins, and drop_cnt becomes 0.
- Timer width is clog2(COPY_TO+1). Timer compares are equality on a saturating-free counter that is cleared on every state entry.

Decomposition:
- Shared package: state encodings (ST_IDLE, ST_ARM, ST_COPY, ST_GAP) and the buffer depth constant (65536) used to size COPY_TO.
- One natural sub-module: frame_decimator (counter, DECIM compare, pend_auto flag).
- The FSM, timer and pending/drop logic stay in the top module.

Test Plan:
- Manual capture with a buffer model (r_done low 2 cycles after r_rd rises, high again 65538 cycles later) -> buf_rd high from t+2 until r_done rises. Then one snap_done pulse, snap_src=1, GAP of 4 low cycles, busy=0 after.
- DECIM=3, auto_en=1, 7 frame_end pulses spaced 70000 cycles apart -> exactly 2 snapshots (after pulses 3 and 6), snap_src=0, drop_cnt=0.
- frame_end and capture_req in the same cycle -> manual copy first, auto copy directly after GAP; 2 snap_done pulses; drop_cnt=0.
- 3 capture_req pulses during one copy -> one extra copy afterwards, drop_cnt=1. Then err_clr -> drop_cnt=0.
- Buffer model that never drops r_done -> after 16 ARM cycles err_timeout=1, buf_rd=0, no snap_done, return to IDLE. Model holding r_done low forever -> timeout after 70000 COPY cycles.
- rst_n asserted mid-COPY -> buf_rd, busy, state_o = 0 asynchronously. After release, a new capture_req starts a clean copy.
